// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state type, word geometry and big-endian byte split for the instruction memory loader
package imem_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state_t;
  localparam int BYTES_PER_WORD = 4;
  typedef logic [BYTES_PER_WORD-1:0][7:0] be_word_t;
  // Element 0 is the byte destined for the lowest address (word bits 31:24).
  function automatic be_word_t to_be_bytes(input logic [31:0] w);
    be_word_t b;
    for (int i = 0; i < BYTES_PER_WORD; i++) b[i] = w[31-8*i -: 8];
    return b;
  endfunction
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: valid/ready word stream feeding the instruction memory loader
interface imem_loader_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  modport master (output in_valid, in_data, input in_ready);
  modport slave (input in_valid, in_data, output in_ready);
endinterface

// File: rtl/imem_byte_array.sv
// imem_byte_array: DEPTH-byte register file with asynchronous clear and a 4-byte aligned write port
module imem_byte_array
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  be_word_t                 data,
  output logic [7:0]               mem [DEPTH]
);
  localparam int AW = $clog2(DEPTH);
  // Clear every byte on reset; otherwise store the four bytes of a word at addr..addr+3.
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we) for (int i = 0; i < BYTES_PER_WORD; i++) mem[addr + AW'(i)] <= data[i];
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams 32-bit words big-endian into instruction memory and holds the CPU in reset until loaded; IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum word
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        num_words,
  imem_loader_if.slave      bus,
  output logic [7:0]        instruction_mem [DEPTH],
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [7:0]        words_loaded
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] MAX_WORDS = 8'(DEPTH / BYTES_PER_WORD);
  loader_state_t    state;
  logic             rdy;
  logic [7:0]       len;
  logic [AW-1:0]    wp;
  logic [WORD_W-1:0] word;
  logic             xfer;
  logic             data_xfer;
  logic             over;
  be_word_t         bytes;
  assign word      = bus.in_data;
  assign bus.in_ready = rdy;
  assign xfer      = bus.in_valid && rdy;
  assign data_xfer = xfer && (words_loaded != len);
  assign over      = num_words > MAX_WORDS;
  assign bytes     = to_be_bytes(word);
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] csum;
  logic              bad;
  assign bad = error || (csum != word);
`else
  logic last;
  assign last = (words_loaded + 8'd1) == len;
`endif
  imem_byte_array #(.DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .rst  (reset),
    .we   (data_xfer),
    .addr (wp),
    .data (bytes),
    .mem  (instruction_mem)
  );
  // Loader FSM with registered handshake, status and CPU reset outputs.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state        <= IDLE;
      rdy          <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_reset    <= 1'b1;
      words_loaded <= '0;
      len          <= '0;
      wp           <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else case (state)
      IDLE, DONE: if (start) begin
        len          <= over ? MAX_WORDS : num_words;
        wp           <= '0;
        words_loaded <= '0;
        error        <= over;
        state        <= (num_words == 8'd0) ? DONE : LOAD;
        rdy          <= num_words != 8'd0;
        done         <= num_words == 8'd0;
        cpu_reset    <= num_words != 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum         <= '0;
`endif
      end
      LOAD: if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (data_xfer) begin
          wp           <= wp + AW'(BYTES_PER_WORD);
          words_loaded <= words_loaded + 8'd1;
          csum         <= csum ^ word;
        end else begin
          state     <= DONE;
          rdy       <= 1'b0;
          done      <= 1'b1;
          error     <= bad;
          cpu_reset <= bad;
        end
`else
        wp           <= wp + AW'(BYTES_PER_WORD);
        words_loaded <= words_loaded + 8'd1;
        if (last) begin
          state     <= DONE;
          rdy       <= 1'b0;
          done      <= 1'b1;
          cpu_reset <= 1'b0;
        end
`endif
      end
      default: state <= IDLE;
    endcase
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  localparam int DEPTH = 256;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [7:0] num_words = '0;
  logic [7:0] instruction_mem [DEPTH];
  logic cpu_reset, done, error;
  logic [7:0] words_loaded;
  int tests = 0;
  int fails = 0;
  logic [31:0] prog [3] = '{32'h20080005, 32'h20090003, 32'h01095020};
  logic [7:0] exp3 [12] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h03, 8'h01, 8'h09, 8'h50, 8'h20};

  imem_loader_if bus ();

  imem_loader #(.DEPTH(DEPTH), .WORD_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words), .bus(bus),
    .instruction_mem(instruction_mem), .cpu_reset(cpu_reset), .done(done),
    .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_start(input logic [7:0] n);
    start = 1'b1;
    num_words = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    bus.in_valid = 1'b1;
    bus.in_data = w;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (cpu_reset !== 1'b1) begin fails++; $display("FAIL reset_cpu_reset: got %b expected 1", cpu_reset); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b expected 0", error); end
    tests++; if (words_loaded !== 8'd0) begin fails++; $display("FAIL reset_words: got %0d expected 0", words_loaded); end
    tests++; if (instruction_mem[0] !== 8'h00) begin fails++; $display("FAIL reset_mem0: got %h expected 00", instruction_mem[0]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_start(8'd3);
    for (int i = 0; i < 3; i++) begin
      tests++; if (words_loaded !== 8'(i)) begin fails++; $display("FAIL b2b_words%0d: got %0d expected %0d", i, words_loaded, i); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL b2b_done_early%0d: got %b expected 0", i, done); end
      send(prog[i]);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(32'h01085026);
`endif
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_done: got %b expected 1", done); end
    tests++; if (cpu_reset !== 1'b0) begin fails++; $display("FAIL b2b_cpu_reset: got %b expected 0", cpu_reset); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL b2b_in_ready: got %b expected 0", bus.in_ready); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL b2b_error: got %b expected 0", error); end
    for (int i = 0; i < 12; i++) begin
      tests++; if (instruction_mem[i] !== exp3[i]) begin fails++; $display("FAIL b2b_byte%0d: got %h expected %h", i, instruction_mem[i], exp3[i]); end
    end
    tests++; if (instruction_mem[12] !== 8'h00) begin fails++; $display("FAIL b2b_byte12: got %h expected 00", instruction_mem[12]); end
  endtask

  task automatic test_bubbles();
    do_reset();
    do_start(8'd3);
    for (int i = 0; i < 3; i++) begin
      tests++; if (words_loaded !== 8'(i)) begin fails++; $display("FAIL bub_words%0d: got %0d expected %0d", i, words_loaded, i); end
      send(prog[i]);
      if (i < 2) begin
        repeat (2) begin
          tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bub_ready%0d: got %b expected 1", i, bus.in_ready); end
          tests++; if (words_loaded !== 8'(i + 1)) begin fails++; $display("FAIL bub_hold%0d: got %0d expected %0d", i, words_loaded, i + 1); end
          @(negedge clk);
        end
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(32'h01085026);
`endif
    tests++; if (words_loaded !== 8'd3) begin fails++; $display("FAIL bub_words_end: got %0d expected 3", words_loaded); end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL bub_done: got %b expected 1", done); end
    for (int i = 0; i < 12; i++) begin
      tests++; if (instruction_mem[i] !== exp3[i]) begin fails++; $display("FAIL bub_byte%0d: got %h expected %h", i, instruction_mem[i], exp3[i]); end
    end
  endtask

  task automatic test_zero();
    int nz;
    do_reset();
    do_start(8'd0);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL zero_done: got %b expected 1", done); end
    tests++; if (cpu_reset !== 1'b0) begin fails++; $display("FAIL zero_cpu_reset: got %b expected 0", cpu_reset); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL zero_in_ready: got %b expected 0", bus.in_ready); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL zero_error: got %b expected 0", error); end
    bus.in_valid = 1'b1;
    bus.in_data = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    nz = 0;
    for (int i = 0; i < DEPTH; i++) if (instruction_mem[i] !== 8'h00) nz++;
    tests++; if (nz !== 0) begin fails++; $display("FAIL zero_mem: got %0d nonzero bytes expected 0", nz); end
  endtask

  task automatic test_overflow();
    int acc;
    do_reset();
    do_start(8'd70);
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL ovf_error_early: got %b expected 1", error); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL ovf_ready: got %b expected 1", bus.in_ready); end
    acc = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 70; i++) begin
      bus.in_data = {8'hAB, 8'(acc), 8'hCD, 8'(acc)};
      if (bus.in_ready === 1'b1) acc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    tests++; if (acc !== 65) begin fails++; $display("FAIL ovf_accepted: got %0d expected 65", acc); end
    tests++; if (cpu_reset !== 1'b1) begin fails++; $display("FAIL ovf_cpu_reset: got %b expected 1", cpu_reset); end
`else
    tests++; if (acc !== 64) begin fails++; $display("FAIL ovf_accepted: got %0d expected 64", acc); end
    tests++; if (cpu_reset !== 1'b0) begin fails++; $display("FAIL ovf_cpu_reset: got %b expected 0", cpu_reset); end
`endif
    tests++; if (words_loaded !== 8'd64) begin fails++; $display("FAIL ovf_words: got %0d expected 64", words_loaded); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL ovf_ready_end: got %b expected 0", bus.in_ready); end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL ovf_done: got %b expected 1", done); end
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL ovf_error: got %b expected 1", error); end
    tests++; if (instruction_mem[255] !== 8'h3F) begin fails++; $display("FAIL ovf_byte255: got %h expected 3f", instruction_mem[255]); end
    tests++; if (instruction_mem[252] !== 8'hAB) begin fails++; $display("FAIL ovf_byte252: got %h expected ab", instruction_mem[252]); end
    tests++; if (instruction_mem[5] !== 8'h01) begin fails++; $display("FAIL ovf_byte5: got %h expected 01", instruction_mem[5]); end
  endtask

  task automatic test_reset_mid_load();
    int nz;
    do_reset();
    do_start(8'd4);
    send(32'h11223344);
    send(32'h55667788);
    tests++; if (instruction_mem[4] !== 8'h55) begin fails++; $display("FAIL mid_written: got %h expected 55", instruction_mem[4]); end
    #2 reset = 1'b1;
    #1;
    nz = 0;
    for (int i = 0; i < DEPTH; i++) if (instruction_mem[i] !== 8'h00) nz++;
    tests++; if (nz !== 0) begin fails++; $display("FAIL mid_clear: got %0d nonzero bytes expected 0", nz); end
    tests++; if (cpu_reset !== 1'b1) begin fails++; $display("FAIL mid_cpu_reset: got %b expected 1", cpu_reset); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL mid_ready: got %b expected 0", bus.in_ready); end
    tests++; if (words_loaded !== 8'd0) begin fails++; $display("FAIL mid_words: got %0d expected 0", words_loaded); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL mid_idle: got %b expected 0", bus.in_ready); end
    do_start(8'd3);
    for (int i = 0; i < 3; i++) send(prog[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(32'h01085026);
`endif
    tests++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin fails++; $display("FAIL mid_reload_done: got done=%b cpu_reset=%b expected 1/0", done, cpu_reset); end
    for (int i = 0; i < 12; i++) begin
      tests++; if (instruction_mem[i] !== exp3[i]) begin fails++; $display("FAIL mid_byte%0d: got %h expected %h", i, instruction_mem[i], exp3[i]); end
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] expb [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h0F, 8'h0F, 8'h0F, 8'h0F};
    do_reset();
    do_start(8'd2);
    send(32'h12345678);
    send(32'h0F0F0F0F);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL cs_wait_trailer: got %b expected 0", done); end
    send(32'h1D3B5977);
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL cs_good_error: got %b expected 0", error); end
    tests++; if (cpu_reset !== 1'b0) begin fails++; $display("FAIL cs_good_cpu_reset: got %b expected 0", cpu_reset); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (instruction_mem[i] !== expb[i]) begin fails++; $display("FAIL cs_byte%0d: got %h expected %h", i, instruction_mem[i], expb[i]); end
    end
    tests++; if (instruction_mem[8] !== 8'h00) begin fails++; $display("FAIL cs_trailer_written: got %h expected 00", instruction_mem[8]); end
    do_start(8'd2);
    tests++; if (cpu_reset !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL cs_restart: got cpu_reset=%b done=%b expected 1/0", cpu_reset, done); end
    send(32'h12345678);
    send(32'h0F0F0F0F);
    send(32'h00000000);
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL cs_bad_error: got %b expected 1", error); end
    tests++; if (cpu_reset !== 1'b1) begin fails++; $display("FAIL cs_bad_cpu_reset: got %b expected 1", cpu_reset); end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL cs_bad_done: got %b expected 1", done); end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_zero();
    test_overflow();
    test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
